// File: rtl/hamming_pkg.sv
// hamming_pkg: shared Hamming (15,11) definitions used by the encoder
// (hamming_core) and the decoder (hamming_decoder).
//   CW_W / DATA_W / PAR_W : codeword, data and parity widths.
//   POS                   : Hamming position of each data bit.
//   hamming_parity(d)     : parity nibble p[3:0] for an 11-bit data word.
//   tx_state_t            : decoder transmit FSM states.
package hamming_pkg;

  localparam int CW_W   = 15;
  localparam int DATA_W = 11;
  localparam int PAR_W  = 4;

  // Data bit i sits at Hamming position POS[i]; powers of two are parity slots.
  localparam logic [PAR_W-1:0] POS [DATA_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // p[k] covers every data bit whose position has bit k set.
  function automatic logic [PAR_W-1:0] hamming_parity(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int k = 0; k < PAR_W; k++) begin
        if (POS[i][k]) p[k] = p[k] ^ d[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/hamming_dec_fix.sv
// hamming_dec_fix: combinational syndrome and single-error correction.
//   cw      in  15  full codeword, c[10:0] data, c[14:11] parity
//   data    out 11  recovered data (corrected or raw, see below)
//   syn     out 4   syndrome
//   err_det out 1   syndrome is nonzero
//   err_fix out 1   a correction was applied
// Macro HAMMING_DEC_CORRECT_EN enables correction; without it the raw data
// bits pass through and err_fix stays 0.
module hamming_dec_fix
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output logic [PAR_W-1:0]  syn,
  output logic              err_det,
  output logic              err_fix
);

  logic [PAR_W-1:0] s;

  always_comb begin
    s       = cw[CW_W-1:DATA_W] ^ hamming_parity(cw[DATA_W-1:0]);
    syn     = s;
    err_det = |s;
    data    = cw[DATA_W-1:0];
`ifdef HAMMING_DEC_CORRECT_EN
    // Parity-slot syndromes (1,2,4,8) match no POS entry, so data is untouched
    // while err_fix still reports that a (parity) bit was corrected.
    for (int i = 0; i < DATA_W; i++) begin
      if (POS[i] == s) data[i] = ~data[i];
    end
    err_fix = |s;
`else
    err_fix = 1'b0;
`endif
  end

endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder: serial Hamming (15,11) decoder.
//   clk      in  1  clock, rising edge
//   rst      in  1  asynchronous active-high reset
//   inp      in  1  serial codeword bit (c[0] first), qualified by inp_vld
//   inp_vld  in  1  input qualifier; gaps pause reception
//   out      out 1  serial corrected data bit, d[0] first
//   out_vld  out 1  high for 11 cycles per frame
//   err_det  out 1  nonzero syndrome for the current frame
//   err_fix  out 1  correction applied to the current frame
//   syn      out 4  syndrome of the current frame
// Macro HAMMING_DEC_CORRECT_EN selects correcting mode (default: detect-only).
module hamming_decoder
  import hamming_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  input  logic             inp_vld,
  output logic             out,
  output logic             out_vld,
  output logic             err_det,
  output logic             err_fix,
  output logic [PAR_W-1:0] syn
);

  logic [3:0]        rx_cnt;
  logic [CW_W-2:0]   sh_p0;
  logic              decode;
  logic [DATA_W-1:0] fix_data;
  logic [PAR_W-1:0]  fix_syn;
  logic              fix_det;
  logic              fix_fix;

  tx_state_t         state;
  logic [3:0]        tx_cnt;
  logic [DATA_W-1:0] tx_data_p1;
  logic [PAR_W-1:0]  syn_p1;
  logic              det_p1;
  logic              fix_p1;

  // Stage 0: serial reception
  assign decode = inp_vld && (rx_cnt == 4'(CW_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
    end else if (inp_vld) begin
      rx_cnt <= decode ? '0 : rx_cnt + 4'd1;
    end
  end

  // Shift right so c[0] lands in sh_p0[0] once c[13] has arrived.
  always_ff @(posedge clk) begin
    if (inp_vld) sh_p0 <= {inp, sh_p0[CW_W-2:1]};
  end

  hamming_dec_fix u_fix (
    .cw      ({inp, sh_p0}),
    .data    (fix_data),
    .syn     (fix_syn),
    .err_det (fix_det),
    .err_fix (fix_fix)
  );

  // Stage 1: frame register and transmit FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= TX_IDLE;
      tx_cnt <= '0;
    end else if (decode) begin
      // Also covers a decode landing on the last bit of the previous frame.
      state  <= TX_SEND;
      tx_cnt <= '0;
    end else if (state == TX_SEND) begin
      if (tx_cnt == 4'(DATA_W - 1)) begin
        state  <= TX_IDLE;
        tx_cnt <= '0;
      end else begin
        tx_cnt <= tx_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (decode) begin
      tx_data_p1 <= fix_data;
      syn_p1     <= fix_syn;
      det_p1     <= fix_det;
      fix_p1     <= fix_fix;
    end
  end

  // Data registers are not reset; gating by out_vld keeps outputs at 0 when idle.
  assign out_vld = (state == TX_SEND);
  assign out     = out_vld & tx_data_p1[tx_cnt];
  assign err_det = out_vld & det_p1;
  assign err_fix = out_vld & fix_p1;
  assign syn     = out_vld ? syn_p1 : '0;

endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: table-driven bench for hamming_decoder plus sequences
// for back-to-back words, reset mid-word/mid-frame and input gaps.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       inp;
  logic       inp_vld;
  logic       out;
  logic       out_vld;
  logic       err_det;
  logic       err_fix;
  logic [3:0] syn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hamming_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .inp     (inp),
    .inp_vld (inp_vld),
    .out     (out),
    .out_vld (out_vld),
    .err_det (err_det),
    .err_fix (err_fix),
    .syn     (syn)
  );

  typedef struct {
    logic [10:0] data;
    logic [3:0]  syn;
    logic        det;
    logic        fix;
    logic        stable;
    int          gap;
  } frame_t;

  typedef struct {
    logic [14:0] cw;
    logic [10:0] fixed;
    logic [3:0]  syn;
    logic        det;
  } vec_t;

  frame_t frames_q[$];
  frame_t cur;
  int     mcnt     = 0;
  int     idle_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Frame collector, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      mcnt     = 0;
      idle_run = 0;
    end else if (out_vld) begin
      if (mcnt == 0) begin
        cur.data   = '0;
        cur.syn    = syn;
        cur.det    = err_det;
        cur.fix    = err_fix;
        cur.stable = 1'b1;
        cur.gap    = idle_run;
      end else if ({syn, err_det, err_fix} !== {cur.syn, cur.det, cur.fix}) begin
        cur.stable = 1'b0;
      end
      cur.data[mcnt] = out;
      mcnt++;
      if (mcnt == 11) begin
        frames_q.push_back(cur);
        mcnt     = 0;
        idle_run = 0;
      end
    end else begin
      if (mcnt != 0) chk("short_frame_len", mcnt, 11);
      mcnt = 0;
      idle_run++;
      chk("idle_outputs_zero", {out, syn, err_det, err_fix}, 0);
    end
  end

  task automatic send_word(input logic [14:0] cw, input bit gaps);
    for (int i = 0; i < 15; i++) begin
      if (gaps) begin
        int g;
        g = int'($urandom_range(0, 2));
        repeat (g) begin
          inp_vld = 1'b0;
          inp     = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      inp     = cw[i];
      inp_vld = 1'b1;
      @(posedge clk); #1;
    end
    inp_vld = 1'b0;
    inp     = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (frames_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (frames_q.size() < n) chk("frame_timeout", frames_q.size(), n);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("async_rst_out_vld", out_vld, 0);
    chk("async_rst_out", {out, syn, err_det, err_fix}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t   tv[7];
  frame_t f;

  initial begin
    logic [10:0] exp_data;
    logic        exp_fix;

    tv[0] = '{15'b110101010010011, 11'b01010010011, 4'b0000, 1'b0};
    tv[1] = '{15'b111010011100101, 11'b10011110101, 4'b1001, 1'b1};
    tv[2] = '{15'b011100000000110, 11'b00000000110, 4'b0100, 1'b1};
    tv[3] = '{15'b000000000000000, 11'b00000000000, 4'b0000, 1'b0};
    tv[4] = '{15'b000000000000001, 11'b00000000000, 4'b0011, 1'b1};
    tv[5] = '{15'b000010000000000, 11'b00000000000, 4'b1111, 1'b1};
    tv[6] = '{15'b000100000000000, 11'b00000000000, 4'b0001, 1'b1};

    rst     = 1'b1;
    inp     = 1'b0;
    inp_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_vld", out_vld, 0);
    chk("reset_out", out, 0);
    chk("reset_syn", syn, 0);
    chk("reset_err_det", err_det, 0);
    chk("reset_err_fix", err_fix, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single words from the table
    for (int v = 0; v < 7; v++) begin
      frames_q.delete();
`ifdef HAMMING_DEC_CORRECT_EN
      exp_data = tv[v].fixed;
      exp_fix  = tv[v].det;
`else
      exp_data = tv[v].cw[10:0];
      exp_fix  = 1'b0;
`endif
      send_word(tv[v].cw, 1'b0);
      wait_frames(1, 30);
      if (frames_q.size() > 0) begin
        f = frames_q.pop_front();
        chk($sformatf("vec%0d_data", v), f.data, exp_data);
        chk($sformatf("vec%0d_syn", v), f.syn, tv[v].syn);
        chk($sformatf("vec%0d_err_det", v), f.det, tv[v].det);
        chk($sformatf("vec%0d_err_fix", v), f.fix, exp_fix);
        chk($sformatf("vec%0d_stable", v), f.stable, 1);
      end
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back words, inp_vld held high for 30 cycles
    frames_q.delete();
    send_word(15'b000011110000000, 1'b0);
    inp_vld = 1'b1;
    send_word(15'b011100000001111, 1'b0);
    wait_frames(2, 40);
    if (frames_q.size() >= 2) begin
      f = frames_q.pop_front();
      chk("b2b_first_data", f.data, 11'b11110000000);
      f = frames_q.pop_front();
      chk("b2b_second_data", f.data, 11'b00000001111);
      chk("b2b_gap", f.gap, 4);
      chk("b2b_second_syn", f.syn, 0);
    end
    repeat (15) @(posedge clk);
    #1;

    // Reset mid-word, then a gapped word: exactly one frame
    frames_q.delete();
    for (int i = 0; i < 7; i++) begin
      inp     = 1'($urandom);
      inp_vld = 1'b1;
      @(posedge clk); #1;
    end
    inp_vld = 1'b0;
    pulse_rst();
    send_word(15'b011000000000011, 1'b1);
    wait_frames(1, 40);
    repeat (30) @(posedge clk);
    #1;
    chk("rst_gap_frame_count", frames_q.size(), 1);
    if (frames_q.size() > 0) begin
      f = frames_q.pop_front();
      chk("rst_gap_data", f.data, 11'b00000000011);
      chk("rst_gap_syn", f.syn, 0);
      chk("rst_gap_err_det", f.det, 0);
    end

    // Reset mid-frame discards the frame
    frames_q.delete();
    send_word(15'b110101010010011, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("midframe_out_vld_before_rst", out_vld, 1);
    pulse_rst();
    repeat (20) @(posedge clk);
    #1;
    chk("midframe_rst_no_frame", frames_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Serial Hamming (15,11) decoder that sits directly downstream of `hamming_core` and consumes its 15-bit serial codewords. For each codeword it:
- computes the 4-bit syndrome;
- corrects any single-bit error;
- streams the 11 recovered data bits out serially, with per-frame error flags.

Reception and transmission overlap, so back-to-back codewords decode without stalls.

## Interface
- No parameters. Widths are fixed by the package constants (`CW_W=15`, `DATA_W=11`, `PAR_W=4`).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inp`  in  1  serial codeword bit, sampled when `inp_vld`=1.
- `inp_vld`  in  1  qualifies `inp`; gaps pause reception.
- `out`  out  1  serial corrected data bit.
- `out_vld`  out  1  high for exactly 11 cycles per decoded frame.
- `err_det`  out  1  nonzero syndrome for the current frame.
- `err_fix`  out  1  a correction was applied to the current frame.
- `syn`  out  4  syndrome of the current frame.

## Operation
- Codeword format (identical to the encoder):
  - `c[10:0]` = data `d`; `c[14:11]` = parity `p[3:0]`.
  - Bit `c[0]` arrives first, `c[14]` last.
  - Data bit `i` has Hamming position `POS[i]` = {3,5,6,7,9,10,11,12,13,14,15} for i=0..10.
  - `p[k]` = XOR of all `d[i]` where `POS[i]` bit k = 1.
- Receive side:
  - 4-bit counter `rx_cnt` (0..14) plus a 14-bit shift register.
  - Each `inp_vld` cycle shifts in `inp` and increments `rx_cnt`.
  - At `rx_cnt`=14 with `inp_vld`, the full word {`inp`, shreg} is decoded combinationally and `rx_cnt` wraps to 0.
- Syndrome: `s[k]` = `c[11+k]` XOR recomputed `p[k]`.
  - `s`=0: no error.
  - `s` ∈ {1,2,4,8}: a parity bit is in error; data passes unchanged; `err_fix`=1.
  - Any other `s`: flip `d[i]` where `POS[i]`=`s`; `err_fix`=1.
- Transmit FSM:
  - States TX_IDLE and TX_SEND; 4-bit `tx_cnt`; 11-bit tx register.
  - A decode event loads the corrected data, `syn`, `err_det` and `err_fix`, then enters TX_SEND.
  - In TX_SEND, `out` = tx_reg[`tx_cnt`] (bit 0 first).
  - After `tx_cnt`=10: return to TX_IDLE, unless a decode event occurs on that same edge, in which case reload and stay in TX_SEND.
- `err_det`, `err_fix` and `syn` hold stable for the whole frame. They read 0 whenever `out_vld`=0.
- `out` reads 0 in TX_IDLE.
- Double errors are not detected: they miscorrect silently. This is inherent to the (15,11) code.

## Timing
- Reset values: `out`=0, `out_vld`=0, `err_det`=0, `err_fix`=0, `syn`=0, `rx_cnt`=0, `tx_cnt`=0, FSM in TX_IDLE.
- Latency: first data bit is presented in the cycle after the edge that samples `c[14]`.
- A frame occupies 11 consecutive cycles. A frame (11 cycles) is shorter than a codeword (15 cycles), so overrun is impossible.
- Back-to-back codewords with `inp_vld` held high produce frames separated by exactly 4 idle cycles.
- `inp_vld` gaps pause `rx_cnt`; bits already collected are kept.
- `rst` asserted mid-word or mid-frame: the partial codeword and the current frame are discarded immediately, and all outputs go to their reset values.

## Configuration
- `HAMMING_DEC_CORRECT_EN` defined: full single-error correction as described above.
- Not defined: detect-only mode.
  - Raw `c[10:0]` is output unchanged.
  - `err_fix` is tied to 0.
  - `err_det` and `syn` still report the syndrome.

## Structure
- `hamming_pkg` holds:
  - `CW_W`, `DATA_W`, `PAR_W`;
  - the `POS` array;
  - function `hamming_parity(d)` returning `p[3:0]`.
- `hamming_core` uses the same package, so encoder and decoder share one mask definition.
- One combinational sub-module, `hamming_dec_fix`: 15-bit codeword in; syndrome, corrected data and flags out. The correction path in it is guarded by the macro.

## Test plan
- Clean word `110101010010011` → `out` serial `01010010011` (LSB first); `err_det`=0, `err_fix`=0, `syn`=0.
- Data bit 4 flipped, `111010011100101` → `out` `10011110101`; `syn`=1001, `err_det`=1, `err_fix`=1.
- Parity bit 13 flipped, `011100000000110` → `out` `00000000110`; `syn`=0100, `err_det`=1, `err_fix`=1.
- Back-to-back `000011110000000` then `011100000001111` (30 contiguous `inp_vld` cycles) → frames `11110000000` and `00000001111`, with exactly 4 `out_vld`=0 cycles between them.
- Reset and gaps:
  - send 7 random bits, pulse `rst`;
  - then send `011000000000011` with random `inp_vld` gaps;
  - → exactly one frame, `00000000011`; no spurious frame.
- Macro undefined, input `111010011100101` → `out` `10011100101` (uncorrected); `syn`=1001, `err_det`=1, `err_fix`=0.
